// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer and HI/LO owner for the Execute stage.
// Define MDU_ABORT_EN to add the abort input that cancels an in-flight operation.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        d_md_use,
`ifdef MDU_ABORT_EN
    input  logic        abort,
`endif
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;
    logic ab, is_md, issue, commit, wr_hi, wr_lo;
    logic [CNT_W-1:0] cnt;
    logic [31:0] s_hi, s_lo;
    logic s_ok;
    logic sgn_op, bz, res_ok;
    logic [31:0] ua, ub, qm, rm, q, r;
    logic [63:0] prod, res;
`ifdef MDU_ABORT_EN
    assign ab = abort;
`else
    assign ab = 1'b0;
`endif
    assign is_md = start && md_op >= 4'd1 && md_op <= 4'd4;
    // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    always_comb begin
        sgn_op = md_op == 4'd1 || md_op == 4'd3;
        prod   = sgn_op ? {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b}
                        : {32'b0, src_a} * {32'b0, src_b};
        ua     = sgn_op && src_a[31] ? -src_a : src_a;
        ub     = sgn_op && src_b[31] ? -src_b : src_b;
        bz     = src_b == 32'd0;
        qm     = ua / (bz ? 32'd1 : ub);
        rm     = ua % (bz ? 32'd1 : ub);
        q      = sgn_op && (src_a[31] ^ src_b[31]) ? -qm : qm;
        r      = sgn_op && src_a[31] ? -rm : rm;
        res    = md_op <= 4'd2 ? prod : {r, q};
        res_ok = md_op <= 4'd2 || !bz;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state == IDLE ? (issue ? RUN : IDLE)
                                 : (ab || cnt == CNT_W'(1) ? IDLE : RUN);
    end
    always_comb begin
        busy   = state == RUN;
        issue  = !busy && is_md && !ab;
        commit = busy && !ab && cnt == CNT_W'(1);
        wr_hi  = !busy && start && !ab && md_op == 4'd5;
        wr_lo  = !busy && start && !ab && md_op == 4'd6;
        stall  = d_md_use && (busy || is_md);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            done <= 1'b0;
            hi   <= '0;
            lo   <= '0;
            s_hi <= '0;
            s_lo <= '0;
            s_ok <= 1'b0;
        end else begin
            cnt  <= issue ? (md_op <= 4'd2 ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES))
                          : (busy && !ab ? cnt - CNT_W'(1) : '0);
            done <= commit;
            if (issue) {s_hi, s_lo, s_ok} <= {res, res_ok};
            else if (busy && ab) {s_hi, s_lo, s_ok} <= '0;
            if (commit && s_ok) {hi, lo} <= {s_hi, s_lo};
            else begin
                if (wr_hi) hi <= src_a;
                if (wr_lo) lo <= src_a;
            end
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed bench for mdu_ctrl with a cycle-level reference model and per-cycle compare.
module tb_mdu_ctrl;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, d_md_use = 1'b0;
    logic [3:0] md_op = 4'd0;
    logic [31:0] src_a = 32'd0, src_b = 32'd0;
    logic [31:0] hi, lo;
    logic busy, stall, done, ab;
    int checks = 0, failures = 0, done_cnt = 0;
`ifdef MDU_ABORT_EN
    logic abort = 1'b0;
    assign ab = abort;
`else
    assign ab = 1'b0;
`endif

    always #5 clk = ~clk;

    mdu_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .src_a(src_a), .src_b(src_b), .d_md_use(d_md_use),
`ifdef MDU_ABORT_EN
        .abort(abort),
`endif
        .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Returns {ok, hi, lo}; ok=0 means a divide by zero that must leave HI/LO alone.
    function automatic logic [64:0] calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa = 64'($signed(a));
        logic signed [63:0] sb = 64'($signed(b));
        logic [63:0] za = {32'd0, a};
        logic [63:0] zb = {32'd0, b};
        logic signed [63:0] sq, sr;
        logic [63:0] p;
        case (op)
            4'd1: begin p = sa * sb; return {1'b1, p}; end
            4'd2: begin p = za * zb; return {1'b1, p}; end
            4'd3: begin
                if (b == 32'd0) return {1'b0, 64'd0};
                sq = sa / sb;
                sr = sa % sb;
                return {1'b1, sr[31:0], sq[31:0]};
            end
            default: begin
                if (b == 32'd0) return {1'b0, 64'd0};
                return {1'b1, a % b, a / b};
            end
        endcase
    endfunction

    logic [31:0] m_hi, m_lo;
    logic [63:0] p_res;
    logic p_ok, m_done;
    int m_rem;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi <= 32'd0; m_lo <= 32'd0; m_rem <= 0; m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem > 0) begin
                if (ab) m_rem <= 0;
                else begin
                    m_rem <= m_rem - 1;
                    if (m_rem == 1) begin
                        m_done <= 1'b1;
                        if (p_ok) begin m_hi <= p_res[63:32]; m_lo <= p_res[31:0]; end
                    end
                end
            end else if (start && !ab) begin
                if (md_op inside {[1:4]}) begin
                    m_rem <= (md_op <= 4'd2) ? 5 : 10;
                    {p_ok, p_res} <= calc(md_op, src_a, src_b);
                end else if (md_op == 4'd5) m_hi <= src_a;
                else if (md_op == 4'd6) m_lo <= src_a;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_hi", hi, m_hi);
        chk("cyc_lo", lo, m_lo);
        chk("cyc_busy", 32'(busy), 32'(m_rem > 0));
        chk("cyc_done", 32'(done), 32'(m_done));
        chk("cyc_stall", 32'(stall), 32'(d_md_use && (m_rem > 0 || (start && md_op inside {[1:4]}))));
        if (done && busy) chk("done_busy_overlap", 32'(done & busy), 32'd0);
        if (done) done_cnt++;
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic use_md);
        @(posedge clk);
        #2 start = 1'b1; md_op = op; src_a = a; src_b = b; d_md_use = use_md;
        #1 chk("issue_stall", 32'(stall), 32'(use_md && op inside {[1:4]}));
        @(posedge clk);
        #2 start = 1'b0; md_op = 4'd0;
    endtask

    task automatic run_wait(input int exp_cycles);
        int n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            chk("busy_stall", 32'(stall), 32'(d_md_use));
            n++;
        end
        chk("busy_len", 32'(n), 32'(exp_cycles));
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_stall", 32'(stall), 32'd0);
    endtask

    initial begin
        int d;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        issue(4'd5, 32'h55, 32'd0, 1'b0);
        chk("mthi_55", hi, 32'h55);
        issue(4'd1, 32'd3, 32'd4, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        d = done_cnt;
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst_no_done", 32'(done_cnt), 32'(d));
        issue(4'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        run_wait(5);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFE);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        issue(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
        run_wait(5);
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);
        issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_wait(10);
        chk("div_hi", hi, 32'hFFFFFFFF);
        chk("div_lo", lo, 32'hFFFFFFFD);
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_wait(10);
        chk("divovf_hi", hi, 32'h0);
        chk("divovf_lo", lo, 32'h80000000);
        issue(4'd4, 32'd5, 32'd0, 1'b0);
        run_wait(10);
        chk("divz_hi", hi, 32'h0);
        chk("divz_lo", lo, 32'h80000000);
        issue(4'd1, 32'd3, 32'd4, 1'b1);
        run_wait(5);
        chk("haz_lo", lo, 32'd12);
        issue(4'd5, 32'h1234, 32'd0, 1'b1);
        chk("mthi_1234", hi, 32'h1234);
        d_md_use = 1'b0;
        issue(4'd3, 32'd100, 32'd7, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 start = 1'b1; md_op = 4'd6; src_a = 32'hAAAA;
        @(posedge clk);
        #2 start = 1'b0; md_op = 4'd0;
        run_wait(7);
        chk("run_ign_lo", lo, 32'd14);
        chk("run_ign_hi", hi, 32'd2);
`ifdef MDU_ABORT_EN
        issue(4'd1, 32'd6, 32'd7, 1'b0);
        repeat (4) @(posedge clk);
        #2 abort = 1'b1;
        @(posedge clk);
        #2 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_hi", hi, 32'd2);
        chk("abort_lo", lo, 32'd14);
        @(posedge clk);
        #2 abort = 1'b1; start = 1'b1; md_op = 4'd5; src_a = 32'h99;
        @(posedge clk);
        #2 abort = 1'b0; start = 1'b0; md_op = 4'd0;
        chk("abort_mthi", hi, 32'd2);
`endif
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
